// File: rtl/std_arb_pkg.sv
// Shared arbitration types: scheduler state encoding and requester-index width helper.
package std_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_e;

  // Index width for n requesters; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping modulo NREQ.
module rr_arbiter
  import std_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] onehot,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  int cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = 0;
    // Scan from the farthest offset down so the nearest request to ptr wins last.
    for (int off = NREQ - 1; off >= 0; off--) begin
      cand = int'(ptr) + off;
      if (cand >= NREQ) cand = cand - NREQ;
      if (req[cand]) begin
        onehot       = '0;
        onehot[cand] = 1'b1;
        idx          = ID_W'(cand);
        any          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xor_gate.sv
// Basic-gates library: bitwise XOR of two WIDTH-bit operands.
module xor_gate #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = a ^ b;

endmodule

// File: rtl/xor_share_arbiter.sv
// Round-robin scheduler sharing one registered XOR datapath among NREQ requesters.
// Handshake: a requester holds req[i] and its operands stable until it samples gnt[i]
// high; the operands are captured on that grant edge and the tagged result appears
// (valid=1) one edge later. en=0 blocks new grants but never cancels an issued one.
module xor_share_arbiter
  import std_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int ID_W  = id_width(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] in0,
  input  logic [NREQ*WIDTH-1:0] in1,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      out0,
  output logic                  valid,
  output logic [ID_W-1:0]       out_id,
  output arb_state_e            dbg_state
);

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0]   win_onehot;
  logic [ID_W-1:0]   win_idx;
  logic              win_any;
  logic              arb;
  logic [WIDTH-1:0]  sel_a, sel_b;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [ID_W-1:0]   id_q;
  logic [WIDTH-1:0]  xor_y;

  // The current grant holder is masked so a level request is not served twice.
  rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .req    (req & ~gnt),
    .ptr    (ptr_q),
    .onehot (win_onehot),
    .idx    (win_idx),
    .any    (win_any)
  );

  always_comb begin
    arb     = en & win_any;
    state_d = IDLE;
    unique case (state_q)
      IDLE:    state_d = arb ? ISSUE : IDLE;
      ISSUE:   state_d = arb ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (arb) ptr_d = (win_idx == ID_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_onehot[i]) begin
        sel_a = in0[i*WIDTH +: WIDTH];
        sel_b = in1[i*WIDTH +: WIDTH];
      end
    end
  end

  xor_gate #(.WIDTH(WIDTH)) u_xor (
    .a (a_q),
    .b (b_q),
    .y (xor_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt     <= arb ? win_onehot : '0;
      if (arb) begin
        a_q  <= sel_a;
        b_q  <= sel_b;
        id_q <= win_idx;
      end
    end
  end

  // ISSUE means a grant happened at the previous edge, so the stage register is live.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0   <= '0;
      out_id <= '0;
      valid  <= 1'b0;
    end else if (state_q == ISSUE) begin
      out0   <= xor_y;
      out_id <= id_q;
      valid  <= 1'b1;
    end else begin
      valid  <= 1'b0;
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_xor_share_arbiter.sv
// Randomized and directed bench for xor_share_arbiter against a queue-based reference model.
module tb_xor_share_arbiter;
  import std_arb_pkg::*;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int ID_W  = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  en;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] in0, in1;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      out0;
  logic                  valid;
  logic [ID_W-1:0]       out_id;
  arb_state_e            dbg_state;

  int checks   = 0;
  int failures = 0;

  // Reference model: grant mask, pointer, and in-order queue of expected {id, result}.
  int                       m_gnt;
  int                       m_ptr;
  logic [ID_W+WIDTH-1:0]    exp_q[$];
  logic [ID_W+WIDTH-1:0]    m_last;

  xor_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .in0       (in0),
    .in1       (in1),
    .gnt       (gnt),
    .out0      (out0),
    .valid     (valid),
    .out_id    (out_id),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_gnt  = 0;
    m_ptr  = 0;
    m_last = '0;
    exp_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_gnt"},   32'(gnt),    32'd0);
    check({tag, "_valid"}, 32'(valid),  32'd0);
    check({tag, "_out0"},  32'(out0),   32'd0);
    check({tag, "_id"},    32'(out_id), 32'd0);
  endtask

  // Predict one rising edge from the current inputs, advance the clock, compare.
  task automatic cycle();
    int elig, w;
    logic exp_valid;
    logic [ID_W+WIDTH-1:0] e;
    exp_valid = (m_gnt != 0);
    elig = int'(req) & ~m_gnt & ((1 << NREQ) - 1);
    w = -1;
    if (en && elig != 0) begin
      for (int k = 0; k < NREQ; k++) begin
        if (w < 0 && elig[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      end
      m_gnt = 1 << w;
      m_ptr = (w + 1) % NREQ;
      exp_q.push_back({ID_W'(w), in0[w*WIDTH +: WIDTH] ^ in1[w*WIDTH +: WIDTH]});
    end else begin
      m_gnt = 0;
    end
    @(posedge clk);
    #1;
    check("gnt",   32'(gnt),   32'(m_gnt));
    check("valid", 32'(valid), 32'(exp_valid));
    check("state", 32'(dbg_state == ISSUE), 32'(m_gnt != 0));
    if (valid) begin
      if (exp_q.size() == 0) begin
        check("sb_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        m_last = e;
        check("out0",   32'(out0),   32'(e[WIDTH-1:0]));
        check("out_id", 32'(out_id), 32'(e[ID_W+WIDTH-1:WIDTH]));
      end
    end else begin
      check("hold", 32'({out_id, out0}), 32'(m_last));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_values("rst_async");
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [NREQ-1:0] exp_seq [5];
    rst_n = 1'b0;
    en    = 1'b1;
    req   = 4'b1111;
    in0   = '0;
    in1   = '0;
    model_reset();

    // Reset held with every requester asserting.
    do_reset();
    req = 4'b0000;

    // Single request from requester 2.
    req = 4'b0100;
    in0[2*WIDTH +: WIDTH] = 8'hA5;
    in1[2*WIDTH +: WIDTH] = 8'h0F;
    cycle();
    check("single_gnt", 32'(gnt), 32'h4);
    req = 4'b0000;
    cycle();
    check("single_out", 32'(out0), 32'hAA);
    check("single_id",  32'(out_id), 32'd2);
    check("single_vld", 32'(valid), 32'd1);

    // Wrap: pointer now 3, requesters 3 and 0 alternate.
    req = 4'b1001;
    in0 = {$urandom, $urandom};
    in1 = {$urandom, $urandom};
    cycle(); check("wrap_g0", 32'(gnt), 32'h8);
    cycle(); check("wrap_g1", 32'(gnt), 32'h1);
    cycle(); check("wrap_g2", 32'(gnt), 32'h8);
    req = 4'b0000;
    cycle();

    // All contend from reset: index order 0,1,2,3,0 and back-to-back results.
    do_reset();
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    req = 4'b1111;
    in0 = {$urandom, $urandom};
    in1 = {$urandom, $urandom};
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("all_seq", 32'(gnt), 32'(exp_seq[i]));
      if (i > 0) check("all_vld", 32'(valid), 32'd1);
    end
    req = 4'b0000;
    cycle();

    // en low: outstanding result drains, no new grant until en returns.
    req = 4'b0001;
    cycle();
    req = 4'b0010;
    en  = 1'b0;
    cycle();
    check("en_nogrant", 32'(gnt), 32'd0);
    check("en_drain",   32'(valid), 32'd1);
    cycle();
    cycle();
    check("en_nogrant3", 32'(gnt), 32'd0);
    en = 1'b1;
    cycle();
    check("en_resume", 32'(gnt), 32'h2);
    req = 4'b0000;
    cycle();

    // Lone level request: grant on alternate cycles.
    req = 4'b0001;
    for (int i = 1; i <= 6; i++) begin
      cycle();
      check("lone_gnt", 32'(gnt[0]), 32'(i % 2));
      check("lone_vld", 32'(valid),  32'((i % 2) == 0));
    end
    req = 4'b0000;
    cycle();

    // Reset mid-transaction: dropped without a result.
    req = 4'b0110;
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_values("rst_mid");
    req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    check("rst_mid_novalid", 32'(valid), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      req = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      en  = ($urandom_range(0, 7) != 0);
      in0 = {$urandom, $urandom};
      in1 = {$urandom, $urandom};
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/xor_share_arbiter.md
# xor_share_arbiter

Round-robin scheduler that shares one WIDTH-bit XOR datapath among NREQ requesters. Each requester presents an operand pair and a request. The block grants one requester per cycle, captures its operands, and returns the registered XOR result tagged with the winner's index one cycle later. It sits between multiple client blocks and the single `xor_gate` instance of the basic-gates library.

## Interface
- `WIDTH`, default 8: operand and result width, ≥1.
- `NREQ`, default 4: number of requesters, ≥2.
- `ID_W`, default `$clog2(NREQ)`: width of the requester index. Derived; not to be overridden.

- `CLK`  in  1  sole clock, rising edge.
- `RSTn`  in  1  reset, asynchronous and active-low.
- `EN`  in  1  when low, no new grants are issued; the pipeline still drains.
- `REQ`  in  NREQ  per-requester request level.
- `IN0`  in  NREQ*WIDTH  operand A; requester i occupies `[i*WIDTH +: WIDTH]`.
- `IN1`  in  NREQ*WIDTH  operand B, same packing as `IN0`.
- `GNT`  out  NREQ  one-hot grant, registered, at most one bit high.
- `OUT0`  out  WIDTH  registered result, `IN0_i ^ IN1_i`.
- `VALID`  out  1  `OUT0` and `OUT_ID` are valid this cycle.
- `OUT_ID`  out  ID_W  index of the requester that owns `OUT0`.

## Operation
- Eligible set at each edge: `REQ & ~GNT`. The requester already holding a grant is masked, so a level request is not granted twice for one transaction.
- Arbitration happens at each rising edge when `EN`=1 and the eligible set is non-empty:
  - The winner is the first eligible index scanning upward, with wrap, from `PTR`.
  - `GNT` is set to the winner's one-hot value for exactly one cycle.
  - The winner's operands are captured into the stage register.
  - `PTR` is set to winner+1, modulo NREQ.
- When no arbitration happens, `GNT` goes to 0 and `PTR` holds.
- Result stage, at the edge after a grant: `OUT0` = captured A ^ B, `OUT_ID` = winner index, `VALID`=1.
  - With no grant at the previous edge, `VALID`=0 and `OUT0`/`OUT_ID` hold their last values.
- Requester handshake:
  - Hold `REQ` and operands stable until `GNT[i]` is sampled high.
  - Deassert `REQ`, or present new operands, from the following cycle.
- Two internal states:
  - `IDLE`: no grant outstanding.
  - `ISSUE`: grant outstanding, operands in the stage register.
  - `IDLE`→`ISSUE` on arbitration. `ISSUE`→`ISSUE` on back-to-back arbitration. `ISSUE`→`IDLE` otherwise.
- `EN` is sampled at the edge. Lowering it stops new grants but never cancels a grant already issued.
- Width rules: XOR is bitwise and has no carry. All index arithmetic is modulo NREQ, including non-power-of-2 NREQ.

## Timing
- Reset (`RSTn`=0, any time, asynchronous): `GNT`=0, `VALID`=0, `OUT0`=0, `OUT_ID`=0, `PTR`=0, state `IDLE`. An in-flight transaction is dropped, with no result.
- Release of reset is synchronous to `CLK`. The first grant is possible at the first edge with `RSTn`=1.
- Latency: grant at edge k, result valid in the cycle after edge k+1.
- Throughput: one result per cycle while at least two requesters contend.
- A lone requester holding `REQ` is granted on alternate cycles, because of the grant mask.
- If all requesters assert simultaneously, they are served in index order starting at `PTR`, with no starvation. Worst-case wait is NREQ-1 grants.
- `PTR` wraps from NREQ-1 to 0.

## Structure
- Shared package `std_arb_pkg`: `clog2`-based ID width helper and the state encoding constants `IDLE` and `ISSUE`.
- Sub-module `rr_arbiter` (parameter NREQ). Inputs: request vector, pointer. Outputs: one-hot winner, winner index, any-valid. It is purely combinational and reusable.
- The datapath instantiates library `xor_gate #(WIDTH)` on the stage register outputs, with a register after it.

## Test plan
- Reset: hold `RSTn`=0 with `REQ`=4'b1111 → `GNT`=0, `VALID`=0, `OUT0`=0, `OUT_ID`=0. Assert `RSTn` low mid-transaction → the same values immediately, and no `VALID` follows.
- Single request: `REQ`=4'b0100, `IN0[2]`=8'hA5, `IN1[2]`=8'h0F → `GNT`=4'b0100 after edge 1. After edge 2: `OUT0`=8'hAA, `OUT_ID`=2, `VALID`=1.
- All contend from reset with REQ held 4'b1111 → grants 0,1,2,3,0 on consecutive edges. `VALID` stays high continuously from the second edge.
- Wrap and fairness: `PTR`=3 with `REQ`=4'b1001 → requester 3 granted, then 0, then 3.
- `EN`=0 for 3 cycles with `REQ`=4'b0010 pending → no `GNT`. An outstanding result still emits. After `EN`=1, the grant goes to 1 on the next edge.
- Lone level request: `REQ`=4'b0001 held for 6 cycles → `GNT[0]` high on cycles 1, 3 and 5 only. `VALID` on cycles 2, 4 and 6.
